// File: rtl/sha_nonce_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sha_nonce_scheduler
//  Purpose  : Collects golden-nonce results from NUM_CORES SHA256 cores.
//             Each core owns a pending register. A round-robin arbiter moves
//             pending results into a show-ahead result FIFO. The FIFO feeds a
//             valid/ready stream toward the host transmit logic. Overwrite
//             attempts on a busy pending slot are counted, not lost silently.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          system clock
//    rst          synchronous active-high reset
//    enable       capture enable for core results
//    data_in      per-core {flag, nonce[31:0]}, slice i at [33i+32:33i]
//    core_ack     one-cycle pulse per core when its result enters the FIFO
//    nonce_out    nonce at FIFO head (0 when empty)
//    core_id      originating core of FIFO head (0 when empty)
//    nonce_valid  FIFO non-empty
//    nonce_ready  consumer accepts head when high together with nonce_valid
//    fifo_full    FIFO holds FIFO_DEPTH entries
//    drop_count   saturating count of cycles with at least one dropped result
//    busy         any pending result or FIFO non-empty
// ============================================================================
module sha_nonce_scheduler #(
    parameter  int NUM_CORES  = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int CID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [33*NUM_CORES-1:0] data_in,
    output logic [NUM_CORES-1:0]   core_ack,
    output logic [31:0]            nonce_out,
    output logic [CID_W-1:0]       core_id,
    output logic                   nonce_valid,
    input  logic                   nonce_ready,
    output logic                   fifo_full,
    output logic [7:0]             drop_count,
    output logic                   busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = CID_W + 32;

    // Per-core capture state
    logic [NUM_CORES-1:0] pending_q, pending_d;
    logic [31:0]          held_q [NUM_CORES];
    logic [31:0]          held_d [NUM_CORES];
    logic [CID_W-1:0]     rr_q, rr_d;

    // Result FIFO
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic [7:0]           drop_q, drop_d;

    logic                 grant_valid;
    logic [CID_W-1:0]     grant_id;
    logic [NUM_CORES-1:0] grant_oh;
    logic [NUM_CORES-1:0] cap_flag;
    logic                 any_drop;
    logic                 push;
    logic                 pop;
    logic [EW-1:0]        head;

    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign nonce_valid = (count_q != '0);
    assign push        = grant_valid;
    assign pop         = nonce_valid && nonce_ready;
    assign head        = mem_q[rd_ptr_q];
    assign nonce_out   = nonce_valid ? head[31:0]    : 32'd0;
    assign core_id     = nonce_valid ? head[EW-1:32] : '0;
    assign core_ack    = ack_q;
    assign drop_count  = drop_q;
    assign busy        = (pending_q != '0) || nonce_valid;

    // Round-robin search starts one past the last granted core, so the core
    // just served has the lowest priority on the next grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        grant_oh    = '0;
        if ((pending_q != '0) && !fifo_full) begin
            for (int k = 1; k <= NUM_CORES; k++) begin
                if (!grant_valid && pending_q[(int'(rr_q) + k) % NUM_CORES]) begin
                    grant_valid = 1'b1;
                    grant_id    = CID_W'((int'(rr_q) + k) % NUM_CORES);
                end
            end
        end
        if (grant_valid) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            cap_flag[i] = enable && data_in[33*i+32];
        end
    end

    always_comb begin
        pending_d = pending_q;
        held_d    = held_q;
        ack_d     = grant_oh;
        any_drop  = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (cap_flag[i]) begin
                // A slot being granted this cycle frees up at the edge, so a
                // fresh result can replace it without counting as a drop.
                if (!pending_q[i] || grant_oh[i]) begin
                    pending_d[i] = 1'b1;
                    held_d[i]    = data_in[33*i +: 32];
                end else begin
                    any_drop = 1'b1;
                end
            end else if (grant_oh[i]) begin
                pending_d[i] = 1'b0;
            end
        end

        rr_d     = grant_valid ? grant_id : rr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        drop_d = (any_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                held_q[i] <= 32'd0;
            end
            rr_q     <= CID_W'(NUM_CORES - 1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= '0;
            drop_q   <= 8'd0;
        end else begin
            pending_q <= pending_d;
            held_q    <= held_d;
            rr_q      <= rr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset: outputs are gated by the count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {grant_id, held_q[grant_id]};
        end
    end

endmodule
`default_nettype wire
